// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling FSM, and a one-entry
// output register with valid/yumi handshake plus parity, framing and overrun flags.
module uart_rx #(
  parameter int clk_per_bit_p = 10416,
  parameter int data_bits_p   = 8,
  parameter int parity_bit_p  = 0,
  parameter int parity_odd_p  = 0,
  parameter int stop_bits_p   = 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   rx_i,
  output logic [data_bits_p-1:0] rx_o,
  output logic                   rx_v_o,
  input  logic                   rx_yumi_i,
  output logic                   rx_parity_err_o,
  output logic                   rx_frame_err_o,
  output logic                   rx_overrun_o,
  output logic                   rx_busy_o
);

  localparam int CntW    = (clk_per_bit_p > 1) ? $clog2(clk_per_bit_p) : 1;
  localparam int MaxBits = (data_bits_p > stop_bits_p) ? data_bits_p : stop_bits_p;
  localparam int BitW    = (MaxBits > 1) ? $clog2(MaxBits) : 1;

  localparam logic [CntW-1:0] LastCnt  = CntW'(clk_per_bit_p - 1);
  localparam logic [CntW-1:0] HalfCnt  = CntW'((clk_per_bit_p - 1) / 2);
  localparam logic [BitW-1:0] LastData = BitW'(data_bits_p - 1);
  localparam logic [BitW-1:0] LastStop = BitW'(stop_bits_p - 1);
  localparam logic            HasPar   = (parity_bit_p != 0);
  localparam logic            OddPar   = (parity_odd_p != 0);

  typedef enum logic [2:0] {
    e_reset,
    e_idle,
    e_start,
    e_data,
    e_parity,
    e_stop
  } state_e;

  state_e                 r_state;
  logic                   r_rx_meta;
  logic                   r_rx_s;
  logic [CntW-1:0]        r_clk_cnt;
  logic [BitW-1:0]        r_bit_cnt;
  logic [data_bits_p-1:0] r_shift;
  logic                   r_xor;
  logic                   r_perr;
  logic                   r_ferr;
  logic [data_bits_p-1:0] r_data;
  logic                   r_v;
  logic                   r_perr_out;
  logic                   r_ferr_out;
  logic                   r_overrun;

  logic w_sample;
  logic w_last_stop;

  assign w_sample    = (r_clk_cnt == LastCnt);
  assign w_last_stop = (r_state == e_stop) && w_sample && (r_bit_cnt == LastStop);

  // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= e_reset;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_xor      <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_data     <= '0;
      r_v        <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;

      // A completing frame wins the register only if it is empty or being drained now.
      if (w_last_stop) begin
        if (!r_v || rx_yumi_i) begin
          r_data     <= r_shift;
          r_perr_out <= r_perr;
          r_ferr_out <= r_ferr | ~r_rx_s;
          r_v        <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (rx_yumi_i) begin
        r_v <= 1'b0;
      end

      case (r_state)
        e_reset: r_state <= e_idle;

        e_idle: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          r_xor     <= 1'b0;
          r_perr    <= 1'b0;
          r_ferr    <= 1'b0;
          if (!r_rx_s) r_state <= e_start;
        end

        e_start: begin
          if (r_clk_cnt == HalfCnt) begin
            r_clk_cnt <= '0;
            r_state   <= r_rx_s ? e_idle : e_data;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        e_data: begin
          if (w_sample) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_s, r_shift[data_bits_p-1:1]};
            r_xor     <= r_xor ^ r_rx_s;
            if (r_bit_cnt == LastData) begin
              r_bit_cnt <= '0;
              r_state   <= HasPar ? e_parity : e_stop;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        e_parity: begin
          if (w_sample) begin
            r_clk_cnt <= '0;
            r_perr    <= r_rx_s ^ r_xor ^ OddPar;
            r_state   <= e_stop;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        e_stop: begin
          if (w_sample) begin
            r_clk_cnt <= '0;
            if (!r_rx_s) r_ferr <= 1'b1;
            if (r_bit_cnt == LastStop) begin
              r_bit_cnt <= '0;
              r_state   <= e_idle;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        default: r_state <= e_idle;
      endcase
    end
  end

  assign rx_o            = r_data;
  assign rx_v_o          = r_v;
  assign rx_parity_err_o = r_perr_out;
  assign rx_frame_err_o  = r_ferr_out;
  assign rx_overrun_o    = r_overrun;
  assign rx_busy_o       = (r_state != e_idle) && (r_state != e_reset);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: three instances (8N1, 7E1, 8N2) at 16 clocks per bit,
// each scenario task drives serial frames and compares against hand-computed values.
module tb_uart_rx;

  localparam int Cpb = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       rxA = 1'b1, yumiA = 1'b0;
  logic [7:0] oA;
  logic       vA, perrA, ferrA, ovrA, busyA;

  logic       rxB = 1'b1, yumiB = 1'b0;
  logic [6:0] oB;
  logic       vB, perrB, ferrB, ovrB, busyB;

  logic       rxC = 1'b1, yumiC = 1'b0;
  logic [7:0] oC;
  logic       vC, perrC, ferrC, ovrC, busyC;

  int checks = 0;
  int passes = 0;
  int ovrCntA = 0;
  int ovrCntC = 0;
  logic busyMid;

  always #5 clk = ~clk;

  uart_rx #(.clk_per_bit_p(Cpb), .data_bits_p(8), .parity_bit_p(0), .parity_odd_p(0), .stop_bits_p(1)) dutA (
    .clk_i(clk), .reset_i(reset), .rx_i(rxA), .rx_o(oA), .rx_v_o(vA), .rx_yumi_i(yumiA),
    .rx_parity_err_o(perrA), .rx_frame_err_o(ferrA), .rx_overrun_o(ovrA), .rx_busy_o(busyA));

  uart_rx #(.clk_per_bit_p(Cpb), .data_bits_p(7), .parity_bit_p(1), .parity_odd_p(0), .stop_bits_p(1)) dutB (
    .clk_i(clk), .reset_i(reset), .rx_i(rxB), .rx_o(oB), .rx_v_o(vB), .rx_yumi_i(yumiB),
    .rx_parity_err_o(perrB), .rx_frame_err_o(ferrB), .rx_overrun_o(ovrB), .rx_busy_o(busyB));

  uart_rx #(.clk_per_bit_p(Cpb), .data_bits_p(8), .parity_bit_p(0), .parity_odd_p(0), .stop_bits_p(2)) dutC (
    .clk_i(clk), .reset_i(reset), .rx_i(rxC), .rx_o(oC), .rx_v_o(vC), .rx_yumi_i(yumiC),
    .rx_parity_err_o(perrC), .rx_frame_err_o(ferrC), .rx_overrun_o(ovrC), .rx_busy_o(busyC));

  // Overrun is a single-cycle pulse, so it is tallied continuously away from the active edge.
  always @(negedge clk) begin
    if (ovrA === 1'b1) ovrCntA = ovrCntA + 1;
    if (ovrC === 1'b1) ovrCntC = ovrCntC + 1;
  end

  task automatic setRx(input int sel, input logic val);
    case (sel)
      0: rxA = val;
      1: rxB = val;
      default: rxC = val;
    endcase
  endtask

  task automatic setYumi(input int sel, input logic val);
    case (sel)
      0: yumiA = val;
      1: yumiB = val;
      default: yumiC = val;
    endcase
  endtask

  function automatic logic getBusy(input int sel);
    case (sel)
      0: return busyA;
      1: return busyB;
      default: return busyC;
    endcase
  endfunction

  // Drives one frame starting at a negedge; optional yumi lands on the completion cycle,
  // which is 10 negedges into the last stop bit (2 sync + 1 idle + 7 half-bit cycles).
  task automatic sendFrame(input int sel, input logic [8:0] data, input int nData,
                           input bit hasPar, input logic parBit, input logic [1:0] stopVals,
                           input int nStop, input bit yumiEnd);
    logic [12:0] bits;
    int nb;
    bits = '0;
    nb = 0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < nData; i++) begin bits[nb] = data[i]; nb++; end
    if (hasPar) begin bits[nb] = parBit; nb++; end
    for (int s = 0; s < nStop; s++) begin bits[nb] = stopVals[s]; nb++; end
    for (int b = 0; b < nb; b++) begin
      setRx(sel, bits[b]);
      for (int c = 0; c < Cpb; c++) begin
        if (yumiEnd && b == nb - 1 && c == 10) setYumi(sel, 1'b1);
        if (yumiEnd && b == nb - 1 && c == 11) setYumi(sel, 1'b0);
        if (b == 4 && c == 8) busyMid = getBusy(sel);
        @(negedge clk);
      end
    end
    setRx(sel, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic pulseYumi(input int sel);
    setYumi(sel, 1'b1);
    @(negedge clk);
    setYumi(sel, 1'b0);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (oA !== 8'h00) $display("[TB] FAIL reset_data got %h want %h", oA, 8'h00); else passes++;
    checks++; if (vA !== 1'b0) $display("[TB] FAIL reset_valid got %b want %b", vA, 1'b0); else passes++;
    checks++; if (busyA !== 1'b0) $display("[TB] FAIL reset_busy got %b want %b", busyA, 1'b0); else passes++;
    checks++; if (ovrA !== 1'b0) $display("[TB] FAIL reset_overrun got %b want %b", ovrA, 1'b0); else passes++;
    checks++; if (perrB !== 1'b0) $display("[TB] FAIL reset_perr got %b want %b", perrB, 1'b0); else passes++;
    checks++; if (ferrC !== 1'b0) $display("[TB] FAIL reset_ferr got %b want %b", ferrC, 1'b0); else passes++;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busyA !== 1'b0) $display("[TB] FAIL idle_busy got %b want %b", busyA, 1'b0); else passes++;
  endtask

  task automatic test_basic;
    sendFrame(0, 9'h0A5, 8, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    checks++; if (busyMid !== 1'b1) $display("[TB] FAIL basic_busy_mid got %b want %b", busyMid, 1'b1); else passes++;
    checks++; if (vA !== 1'b1) $display("[TB] FAIL basic_valid got %b want %b", vA, 1'b1); else passes++;
    checks++; if (oA !== 8'hA5) $display("[TB] FAIL basic_data got %h want %h", oA, 8'hA5); else passes++;
    checks++; if (perrA !== 1'b0) $display("[TB] FAIL basic_perr got %b want %b", perrA, 1'b0); else passes++;
    checks++; if (ferrA !== 1'b0) $display("[TB] FAIL basic_ferr got %b want %b", ferrA, 1'b0); else passes++;
    checks++; if (busyA !== 1'b0) $display("[TB] FAIL basic_busy_end got %b want %b", busyA, 1'b0); else passes++;
    repeat (5) @(negedge clk);
    checks++; if (vA !== 1'b1) $display("[TB] FAIL basic_valid_held got %b want %b", vA, 1'b1); else passes++;
    pulseYumi(0);
    checks++; if (vA !== 1'b0) $display("[TB] FAIL basic_valid_after_yumi got %b want %b", vA, 1'b0); else passes++;
    checks++; if (oA !== 8'hA5) $display("[TB] FAIL basic_data_after_yumi got %h want %h", oA, 8'hA5); else passes++;
    checks++; if (ovrCntA !== 0) $display("[TB] FAIL basic_no_overrun got %0d want %0d", ovrCntA, 0); else passes++;
  endtask

  task automatic test_parity;
    sendFrame(1, 9'h007, 7, 1'b1, 1'b1, 2'b11, 1, 1'b0);
    checks++; if (vB !== 1'b1) $display("[TB] FAIL par_good_valid got %b want %b", vB, 1'b1); else passes++;
    checks++; if (oB !== 7'h07) $display("[TB] FAIL par_good_data got %h want %h", oB, 7'h07); else passes++;
    checks++; if (perrB !== 1'b0) $display("[TB] FAIL par_good_perr got %b want %b", perrB, 1'b0); else passes++;
    pulseYumi(1);
    sendFrame(1, 9'h007, 7, 1'b1, 1'b0, 2'b11, 1, 1'b0);
    checks++; if (vB !== 1'b1) $display("[TB] FAIL par_bad_valid got %b want %b", vB, 1'b1); else passes++;
    checks++; if (oB !== 7'h07) $display("[TB] FAIL par_bad_data got %h want %h", oB, 7'h07); else passes++;
    checks++; if (perrB !== 1'b1) $display("[TB] FAIL par_bad_perr got %b want %b", perrB, 1'b1); else passes++;
    checks++; if (ferrB !== 1'b0) $display("[TB] FAIL par_bad_ferr got %b want %b", ferrB, 1'b0); else passes++;
  endtask

  task automatic test_frame_err;
    sendFrame(2, 9'h03C, 8, 1'b0, 1'b0, 2'b01, 2, 1'b0);
    checks++; if (vC !== 1'b1) $display("[TB] FAIL ferr_valid got %b want %b", vC, 1'b1); else passes++;
    checks++; if (oC !== 8'h3C) $display("[TB] FAIL ferr_data got %h want %h", oC, 8'h3C); else passes++;
    checks++; if (ferrC !== 1'b1) $display("[TB] FAIL ferr_flag got %b want %b", ferrC, 1'b1); else passes++;
    checks++; if (perrC !== 1'b0) $display("[TB] FAIL ferr_perr got %b want %b", perrC, 1'b0); else passes++;
    pulseYumi(2);
    sendFrame(2, 9'h055, 8, 1'b0, 1'b0, 2'b11, 2, 1'b0);
    checks++; if (vC !== 1'b1) $display("[TB] FAIL after_ferr_valid got %b want %b", vC, 1'b1); else passes++;
    checks++; if (oC !== 8'h55) $display("[TB] FAIL after_ferr_data got %h want %h", oC, 8'h55); else passes++;
    checks++; if (ferrC !== 1'b0) $display("[TB] FAIL after_ferr_flag got %b want %b", ferrC, 1'b0); else passes++;
    checks++; if (ovrCntC !== 0) $display("[TB] FAIL after_ferr_overrun got %0d want %0d", ovrCntC, 0); else passes++;
  endtask

  task automatic test_glitch;
    int ovrBase;
    ovrBase = ovrCntA;
    rxA = 1'b0;
    repeat (3) @(negedge clk);
    rxA = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busyA !== 1'b1) $display("[TB] FAIL glitch_busy_start got %b want %b", busyA, 1'b1); else passes++;
    repeat (20) @(negedge clk);
    checks++; if (busyA !== 1'b0) $display("[TB] FAIL glitch_busy_end got %b want %b", busyA, 1'b0); else passes++;
    checks++; if (vA !== 1'b0) $display("[TB] FAIL glitch_valid got %b want %b", vA, 1'b0); else passes++;
    checks++; if (ovrCntA !== ovrBase) $display("[TB] FAIL glitch_overrun got %0d want %0d", ovrCntA, ovrBase); else passes++;
    sendFrame(0, 9'h0C3, 8, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    checks++; if (oA !== 8'hC3) $display("[TB] FAIL glitch_next_data got %h want %h", oA, 8'hC3); else passes++;
    pulseYumi(0);
  endtask

  task automatic test_back_to_back;
    int ovrBase;
    ovrBase = ovrCntA;
    sendFrame(0, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    sendFrame(0, 9'h022, 8, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    checks++; if (vA !== 1'b1) $display("[TB] FAIL b2b_valid got %b want %b", vA, 1'b1); else passes++;
    checks++; if (oA !== 8'h11) $display("[TB] FAIL b2b_held_data got %h want %h", oA, 8'h11); else passes++;
    checks++; if (ovrCntA - ovrBase !== 1) $display("[TB] FAIL b2b_overrun_pulses got %0d want %0d", ovrCntA - ovrBase, 1); else passes++;
    checks++; if (ovrA !== 1'b0) $display("[TB] FAIL b2b_overrun_low got %b want %b", ovrA, 1'b0); else passes++;
    pulseYumi(0);
    ovrBase = ovrCntA;
    sendFrame(0, 9'h011, 8, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    sendFrame(0, 9'h022, 8, 1'b0, 1'b0, 2'b11, 1, 1'b1);
    checks++; if (vA !== 1'b1) $display("[TB] FAIL b2b_yumi_valid got %b want %b", vA, 1'b1); else passes++;
    checks++; if (oA !== 8'h22) $display("[TB] FAIL b2b_yumi_data got %h want %h", oA, 8'h22); else passes++;
    checks++; if (ovrCntA - ovrBase !== 0) $display("[TB] FAIL b2b_yumi_overrun got %0d want %0d", ovrCntA - ovrBase, 0); else passes++;
  endtask

  task automatic test_reset_midframe;
    rxA = 1'b0;
    repeat (Cpb) @(negedge clk);
    rxA = 1'b1;
    repeat (3 * Cpb + Cpb / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (oA !== 8'h00) $display("[TB] FAIL midrst_data got %h want %h", oA, 8'h00); else passes++;
    checks++; if (vA !== 1'b0) $display("[TB] FAIL midrst_valid got %b want %b", vA, 1'b0); else passes++;
    checks++; if (busyA !== 1'b0) $display("[TB] FAIL midrst_busy got %b want %b", busyA, 1'b0); else passes++;
    checks++; if (vB !== 1'b0) $display("[TB] FAIL midrst_valid_b got %b want %b", vB, 1'b0); else passes++;
    checks++; if (perrB !== 1'b0) $display("[TB] FAIL midrst_perr_b got %b want %b", perrB, 1'b0); else passes++;
    checks++; if (oC !== 8'h00) $display("[TB] FAIL midrst_data_c got %h want %h", oC, 8'h00); else passes++;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    sendFrame(0, 9'h081, 8, 1'b0, 1'b0, 2'b11, 1, 1'b0);
    checks++; if (vA !== 1'b1) $display("[TB] FAIL postrst_valid got %b want %b", vA, 1'b1); else passes++;
    checks++; if (oA !== 8'h81) $display("[TB] FAIL postrst_data got %h want %h", oA, 8'h81); else passes++;
    checks++; if (ferrA !== 1'b0) $display("[TB] FAIL postrst_ferr got %b want %b", ferrA, 1'b0); else passes++;
  endtask

  initial begin
    busyMid = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
